// File: rtl/tri_fu_mul_rslv.sv
// Sequential carry-propagate resolver: adds a 108-bit sum/carry pair in four
// 27-bit slices (LSB slice first) and returns product, carry-out and low-half sticky.
module tri_fu_mul_rslv #(
  parameter int SLICE = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:4*SLICE] in_sum,
  input  logic [1:4*SLICE] in_car,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:4*SLICE] out_prod,
  output logic             out_co,
  output logic             out_sticky
);

  localparam int W = 4 * SLICE;

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, DONE} state_t;

  state_t           state_reg, state_next;
  logic [1:W]       hold_sum_reg, hold_car_reg;
  logic [1:W]       out_prod_reg;
  logic             carry_reg;
  logic             out_co_reg, out_sticky_reg;
  logic             capture, busy;
  logic [1:0]       slice_idx;
  logic [SLICE-1:0] slice_res;
  logic             slice_co;
  logic [SLICE-1:0] sum_slc [4];
  logic [SLICE-1:0] car_slc [4];

  // Slice gi spans bits [W+1-SLICE*(gi+1) : W-SLICE*gi]; slice 0 is the LSB end.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slc
      assign sum_slc[gi] = hold_sum_reg[W+1-SLICE*(gi+1) : W-SLICE*gi];
      assign car_slc[gi] = hold_car_reg[W+1-SLICE*(gi+1) : W-SLICE*gi];
    end
  endgenerate

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign capture   = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == S0) || (state_reg == S1) ||
                     (state_reg == S2) || (state_reg == S3);
  assign out_prod   = out_prod_reg;
  assign out_co     = out_co_reg;
  assign out_sticky = out_sticky_reg;

  always_comb begin
    slice_idx = 2'd0;
    case (state_reg)
      S1:      slice_idx = 2'd1;
      S2:      slice_idx = 2'd2;
      S3:      slice_idx = 2'd3;
      default: slice_idx = 2'd0;
    endcase
  end

  assign {slice_co, slice_res} = {1'b0, sum_slc[slice_idx]} +
                                 {1'b0, car_slc[slice_idx]} +
                                 {{SLICE{1'b0}}, carry_reg};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture) state_next = S0;
      S0:      state_next = S1;
      S1:      state_next = S2;
      S2:      state_next = S3;
      S3:      state_next = DONE;
      DONE:    if (out_ready) state_next = capture ? S0 : IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_sum_reg <= '0;
      hold_car_reg <= '0;
    end else if (capture && !flush) begin
      hold_sum_reg <= in_sum;
      hold_car_reg <= in_car;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_reg      <= 1'b0;
      out_prod_reg   <= '0;
      out_co_reg     <= 1'b0;
      out_sticky_reg <= 1'b0;
    end else if (flush || capture) begin
      carry_reg <= 1'b0;
    end else if (busy) begin
      carry_reg <= slice_co;
      case (state_reg)
        S0: out_prod_reg[W-SLICE+1 : W]         <= slice_res;
        S1: out_prod_reg[W-2*SLICE+1 : W-SLICE] <= slice_res;
        S2: out_prod_reg[W-3*SLICE+1 : W-2*SLICE] <= slice_res;
        default: begin
          out_prod_reg[1 : SLICE] <= slice_res;
          out_co_reg              <= slice_co;
          // Low half is already registered by the time the top slice resolves.
          out_sticky_reg          <= |out_prod_reg[W-2*SLICE+1 : W];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_fu_mul_rslv.sv
// Directed bench for tri_fu_mul_rslv: hand-computed vectors, backpressure,
// flush, async reset, plus a short randomized pass against a 109-bit adder model.
module tb_tri_fu_mul_rslv;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:108] in_sum;
  logic [1:108] in_car;
  logic         out_valid;
  logic         out_ready;
  logic [1:108] out_prod;
  logic         out_co;
  logic         out_sticky;

  int checks   = 0;
  int failures = 0;

  tri_fu_mul_rslv #(.SLICE(27)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_car    (in_car),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_co    (out_co),
    .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [107:0] got, input logic [107:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-width reference: product, carry-out, sticky over the low 54 bits.
  task automatic model(input logic [107:0] s, input logic [107:0] c,
                       output logic [107:0] p, output logic co, output logic st);
    logic [108:0] full;
    full = {1'b0, s} + {1'b0, c};
    p    = full[107:0];
    co   = full[108];
    st   = |full[53:0];
  endtask

  // Capture a pair, wait for the result, check it, stall, then drain.
  task automatic run_op(input string tag, input logic [107:0] s, input logic [107:0] c,
                        input int stall);
    logic [107:0] ep;
    logic         eco, est;
    int           n;
    model(s, c, ep, eco, est);
    in_sum    = s;
    in_car    = c;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, 108'(in_ready), 108'(1));
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 108'(n), 108'(4));
    chk({tag, "_prod"}, out_prod, ep);
    chk({tag, "_co"}, 108'(out_co), 108'(eco));
    chk({tag, "_sticky"}, 108'(out_sticky), 108'(est));
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) tick();
      chk({tag, "_stall_prod"}, out_prod, ep);
      chk({tag, "_stall_valid"}, 108'(out_valid), 108'(1));
      out_ready = 1'b1;
    end
    tick();
    $display("op %s sum=%h car=%h prod=%h co=%0d sticky=%0d", tag, s, c, ep, eco, est);
  endtask

  initial begin
    logic [107:0] s, c;
    int           seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sum = '0; in_car = '0;
    repeat (2) tick();
    chk("rst_out_valid", 108'(out_valid), 108'(0));
    chk("rst_in_ready", 108'(in_ready), 108'(1));
    chk("rst_prod", out_prod, 108'(0));
    chk("rst_co", 108'(out_co), 108'(0));
    chk("rst_sticky", 108'(out_sticky), 108'(0));
    rst = 1'b0;

    run_op("basic", 108'h1, 108'h1, 0);
    chk("basic_drain", 108'(out_valid), 108'(0));
    run_op("ripple", {108{1'b1}}, 108'h1, 0);

    // Backpressure: result 7 held for 3 cycles, second pair captured on drain.
    in_sum = 108'h3; in_car = 108'h4; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 108'(out_valid), 108'(1));
      chk("bp_prod", out_prod, 108'h7);
      chk("bp_in_ready", 108'(in_ready), 108'(0));
      tick();
    end
    s = 108'h8000000 << 54;
    in_sum = s; in_car = 108'h0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("bp_drain_ready", 108'(in_ready), 108'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_second_busy", 108'(out_valid), 108'(0));
    repeat (4) tick();
    chk("bp2_valid", 108'(out_valid), 108'(1));
    chk("bp2_prod", out_prod, s);
    chk("bp2_sticky", 108'(out_sticky), 108'(0));
    chk("bp2_co", 108'(out_co), 108'(0));
    tick();
    $display("op backpressure pairs=(3,4),(%h,0)", s);

    // Flush during S2.
    in_sum = 108'h9; in_car = 108'h9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", 108'(in_ready), 108'(1));
    seen = 0;
    repeat (6) begin
      if (out_valid) seen++;
      tick();
    end
    chk("flush_no_valid", 108'(seen), 108'(0));
    run_op("after_flush", 108'h5, 108'h6, 0);

    // Flush coinciding with a capture drops the pair.
    in_sum = 108'h7; in_car = 108'h7; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (6) begin
      if (out_valid) seen++;
      tick();
    end
    chk("flush_cap_no_valid", 108'(seen), 108'(0));
    run_op("after_flush_cap", 108'h2, 108'h3, 0);

    // Async reset while a result is held.
    in_sum = 108'h1; in_car = 108'h2; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("ar_valid_before", 108'(out_valid), 108'(1));
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", 108'(out_valid), 108'(0));
    chk("ar_prod", out_prod, 108'(0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_reset", 108'h1, 108'h1, 0);

    // Randomized pairs with occasional stalls and flushes.
    for (int i = 0; i < 200; i++) begin
      s = 108'({$urandom, $urandom, $urandom, $urandom});
      c = 108'({$urandom, $urandom, $urandom, $urandom});
      if (i % 7 == 3) c = ~s;
      if ($urandom_range(0, 9) == 0) begin
        in_sum = s; in_car = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("rnd_flush_idle", 108'(out_valid), 108'(0));
      end
      run_op("rnd", s, c, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
